// File: rtl/veerwolf_ram_init_pkg.sv
// Shared types and AXI constants for the post-reset RAM fill-and-verify initiator.
package veerwolf_ram_init_pkg;

    typedef enum logic [2:0] {
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        DONE
    } state_t;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_64    = 3'd3;

    // Test word for a byte address: inverted address in the upper half.
    function automatic logic [63:0] pattern(input logic [31:0] addr);
        return {~addr, addr};
    endfunction

endpackage

// File: rtl/veerwolf_ram_init.sv
// AXI4 initiator that fills RAM with an address-derived pattern after reset,
// then optionally reads every word back and flags the first mismatch.
module veerwolf_ram_init
    import veerwolf_ram_init_pkg::*;
#(
    parameter int unsigned RAM_SIZE  = 32'h10000,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned ID_WIDTH  = 6,
    parameter bit          VERIFY    = 1'b1
) (
    input  logic                clk,
    input  logic                rstn,

    output logic [ID_WIDTH-1:0] o_ram_awid,
    output logic [31:0]         o_ram_awaddr,
    output logic [7:0]          o_ram_awlen,
    output logic [2:0]          o_ram_awsize,
    output logic [1:0]          o_ram_awburst,
    output logic                o_ram_awlock,
    output logic [3:0]          o_ram_awcache,
    output logic [2:0]          o_ram_awprot,
    output logic [3:0]          o_ram_awregion,
    output logic [3:0]          o_ram_awqos,
    output logic                o_ram_awvalid,
    input  logic                i_ram_awready,

    output logic [63:0]         o_ram_wdata,
    output logic [7:0]          o_ram_wstrb,
    output logic                o_ram_wlast,
    output logic                o_ram_wvalid,
    input  logic                i_ram_wready,

    input  logic [ID_WIDTH-1:0] i_ram_bid,
    input  logic [1:0]          i_ram_bresp,
    input  logic                i_ram_bvalid,
    output logic                o_ram_bready,

    output logic [ID_WIDTH-1:0] o_ram_arid,
    output logic [31:0]         o_ram_araddr,
    output logic [7:0]          o_ram_arlen,
    output logic [2:0]          o_ram_arsize,
    output logic [1:0]          o_ram_arburst,
    output logic                o_ram_arlock,
    output logic [3:0]          o_ram_arcache,
    output logic [2:0]          o_ram_arprot,
    output logic [3:0]          o_ram_arregion,
    output logic [3:0]          o_ram_arqos,
    output logic                o_ram_arvalid,
    input  logic                i_ram_arready,

    input  logic [ID_WIDTH-1:0] i_ram_rid,
    input  logic [63:0]         i_ram_rdata,
    input  logic [1:0]          i_ram_rresp,
    input  logic                i_ram_rlast,
    input  logic                i_ram_rvalid,
    output logic                o_ram_rready,

    output logic                o_init_done,
    output logic                o_init_error,
    output logic [31:0]         o_err_addr
);

    localparam int unsigned      WORDS    = RAM_SIZE / 8;
    localparam int unsigned      CW       = $clog2(WORDS);
    localparam logic [CW-1:0]    LAST_CNT = CW'(WORDS - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   addr;
    logic          aw_done;
    logic          w_done;
    logic          aw_hs;
    logic          w_hs;
    logic          rd_bad;
    logic          unused_ids;

    assign addr       = BASE_ADDR + 32'({cnt, 3'b000});
    assign unused_ids = ^{i_ram_bid, i_ram_rid};

    assign o_ram_awid     = '0;
    assign o_ram_awaddr   = addr;
    assign o_ram_awlen    = '0;
    assign o_ram_awsize   = SIZE_64;
    assign o_ram_awburst  = BURST_INCR;
    assign o_ram_awlock   = 1'b0;
    assign o_ram_awcache  = '0;
    assign o_ram_awprot   = '0;
    assign o_ram_awregion = '0;
    assign o_ram_awqos    = '0;

    assign o_ram_wdata    = pattern(addr);
    assign o_ram_wstrb    = '1;
    assign o_ram_wlast    = 1'b1;

    assign o_ram_arid     = '0;
    assign o_ram_araddr   = addr;
    assign o_ram_arlen    = '0;
    assign o_ram_arsize   = SIZE_64;
    assign o_ram_arburst  = BURST_INCR;
    assign o_ram_arlock   = 1'b0;
    assign o_ram_arcache  = '0;
    assign o_ram_arprot   = '0;
    assign o_ram_arregion = '0;
    assign o_ram_arqos    = '0;

    always_comb begin
        aw_hs  = o_ram_awvalid && i_ram_awready;
        w_hs   = o_ram_wvalid && i_ram_wready;
        rd_bad = (i_ram_rresp != RESP_OKAY) || !i_ram_rlast ||
                 (i_ram_rdata != pattern(addr));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= WR_REQ;
            cnt           <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            o_ram_awvalid <= 1'b0;
            o_ram_wvalid  <= 1'b0;
            o_ram_bready  <= 1'b0;
            o_ram_arvalid <= 1'b0;
            o_ram_rready  <= 1'b0;
            o_init_done   <= 1'b0;
            o_init_error  <= 1'b0;
            o_err_addr    <= '0;
        end else begin
            case (state)
                WR_REQ: begin
                    // Nothing raised and nothing completed only happens on the first cycle after reset.
                    if (!o_ram_awvalid && !o_ram_wvalid && !aw_done && !w_done) begin
                        o_ram_awvalid <= 1'b1;
                        o_ram_wvalid  <= 1'b1;
                    end else begin
                        if (aw_hs) begin
                            o_ram_awvalid <= 1'b0;
                            aw_done       <= 1'b1;
                        end
                        if (w_hs) begin
                            o_ram_wvalid <= 1'b0;
                            w_done       <= 1'b1;
                        end
                        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                            aw_done      <= 1'b0;
                            w_done       <= 1'b0;
                            o_ram_bready <= 1'b1;
                            state        <= WR_RESP;
                        end
                    end
                end

                WR_RESP: begin
                    if (i_ram_bvalid) begin
                        o_ram_bready <= 1'b0;
                        if (i_ram_bresp != RESP_OKAY) begin
                            o_err_addr   <= addr;
                            o_init_error <= 1'b1;
                            o_init_done  <= 1'b1;
                            state        <= DONE;
                        end else if (cnt == LAST_CNT) begin
                            if (VERIFY) begin
                                cnt           <= '0;
                                o_ram_arvalid <= 1'b1;
                                state         <= RD_REQ;
                            end else begin
                                o_init_done <= 1'b1;
                                state       <= DONE;
                            end
                        end else begin
                            cnt           <= cnt + 1'b1;
                            o_ram_awvalid <= 1'b1;
                            o_ram_wvalid  <= 1'b1;
                            state         <= WR_REQ;
                        end
                    end
                end

                RD_REQ: begin
                    if (i_ram_arready) begin
                        o_ram_arvalid <= 1'b0;
                        o_ram_rready  <= 1'b1;
                        state         <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (i_ram_rvalid) begin
                        o_ram_rready <= 1'b0;
                        if (rd_bad) begin
                            o_err_addr   <= addr;
                            o_init_error <= 1'b1;
                            o_init_done  <= 1'b1;
                            state        <= DONE;
                        end else if (cnt == LAST_CNT) begin
                            o_init_done <= 1'b1;
                            state       <= DONE;
                        end else begin
                            cnt           <= cnt + 1'b1;
                            o_ram_arvalid <= 1'b1;
                            state         <= RD_REQ;
                        end
                    end
                end

                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_veerwolf_ram_init.sv
// Bench: AXI RAM responder with configurable stalls and fault injection,
// scoreboard queues for AW/W/AR/completion, plus a write-only instance.
module tb_veerwolf_ram_init;

    localparam logic [31:0] NONE = 32'hFFFF_FFFF;
    localparam logic [63:0] PAT [8] = '{
        64'hFFFFFFFF_00000000, 64'hFFFFFFF7_00000008,
        64'hFFFFFFEF_00000010, 64'hFFFFFFE7_00000018,
        64'hFFFFFFDF_00000020, 64'hFFFFFFD7_00000028,
        64'hFFFFFFCF_00000030, 64'hFFFFFFC7_00000038
    };

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [5:0]  o_ram_awid, o_ram_arid, i_ram_bid, i_ram_rid;
    logic [31:0] o_ram_awaddr, o_ram_araddr, o_err_addr;
    logic [7:0]  o_ram_awlen, o_ram_arlen, o_ram_wstrb;
    logic [2:0]  o_ram_awsize, o_ram_arsize, o_ram_awprot, o_ram_arprot;
    logic [1:0]  o_ram_awburst, o_ram_arburst, i_ram_bresp, i_ram_rresp;
    logic [3:0]  o_ram_awcache, o_ram_arcache, o_ram_awregion, o_ram_arregion, o_ram_awqos, o_ram_arqos;
    logic        o_ram_awlock, o_ram_arlock, o_ram_awvalid, o_ram_arvalid, o_ram_wvalid, o_ram_wlast;
    logic        i_ram_awready, i_ram_wready, i_ram_arready, i_ram_bvalid, i_ram_rvalid, i_ram_rlast;
    logic        o_ram_bready, o_ram_rready, o_init_done, o_init_error;
    logic [63:0] o_ram_wdata, i_ram_rdata;

    logic [5:0]  v_awid, v_arid, v_bid, v_rid;
    logic [31:0] v_awaddr, v_araddr, v_err_addr;
    logic [7:0]  v_awlen, v_arlen, v_wstrb;
    logic [2:0]  v_awsize, v_arsize, v_awprot, v_arprot;
    logic [1:0]  v_awburst, v_arburst, v_bresp, v_rresp;
    logic [3:0]  v_awcache, v_arcache, v_awregion, v_arregion, v_awqos, v_arqos;
    logic        v_awlock, v_arlock, v_awvalid, v_arvalid, v_wvalid, v_wlast;
    logic        v_awready, v_wready, v_arready, v_bvalid, v_rvalid, v_rlast;
    logic        v_bready, v_rready, v_done, v_error;
    logic [63:0] v_wdata, v_rdata;

    veerwolf_ram_init #(.RAM_SIZE(64), .BASE_ADDR(32'h0), .ID_WIDTH(6), .VERIFY(1'b1)) dut (
        .clk(clk), .rstn(rstn),
        .o_ram_awid(o_ram_awid), .o_ram_awaddr(o_ram_awaddr), .o_ram_awlen(o_ram_awlen),
        .o_ram_awsize(o_ram_awsize), .o_ram_awburst(o_ram_awburst), .o_ram_awlock(o_ram_awlock),
        .o_ram_awcache(o_ram_awcache), .o_ram_awprot(o_ram_awprot), .o_ram_awregion(o_ram_awregion),
        .o_ram_awqos(o_ram_awqos), .o_ram_awvalid(o_ram_awvalid), .i_ram_awready(i_ram_awready),
        .o_ram_wdata(o_ram_wdata), .o_ram_wstrb(o_ram_wstrb), .o_ram_wlast(o_ram_wlast),
        .o_ram_wvalid(o_ram_wvalid), .i_ram_wready(i_ram_wready),
        .i_ram_bid(i_ram_bid), .i_ram_bresp(i_ram_bresp), .i_ram_bvalid(i_ram_bvalid), .o_ram_bready(o_ram_bready),
        .o_ram_arid(o_ram_arid), .o_ram_araddr(o_ram_araddr), .o_ram_arlen(o_ram_arlen),
        .o_ram_arsize(o_ram_arsize), .o_ram_arburst(o_ram_arburst), .o_ram_arlock(o_ram_arlock),
        .o_ram_arcache(o_ram_arcache), .o_ram_arprot(o_ram_arprot), .o_ram_arregion(o_ram_arregion),
        .o_ram_arqos(o_ram_arqos), .o_ram_arvalid(o_ram_arvalid), .i_ram_arready(i_ram_arready),
        .i_ram_rid(i_ram_rid), .i_ram_rdata(i_ram_rdata), .i_ram_rresp(i_ram_rresp),
        .i_ram_rlast(i_ram_rlast), .i_ram_rvalid(i_ram_rvalid), .o_ram_rready(o_ram_rready),
        .o_init_done(o_init_done), .o_init_error(o_init_error), .o_err_addr(o_err_addr)
    );

    veerwolf_ram_init #(.RAM_SIZE(64), .BASE_ADDR(32'h0), .ID_WIDTH(6), .VERIFY(1'b0)) dut_nv (
        .clk(clk), .rstn(rstn),
        .o_ram_awid(v_awid), .o_ram_awaddr(v_awaddr), .o_ram_awlen(v_awlen),
        .o_ram_awsize(v_awsize), .o_ram_awburst(v_awburst), .o_ram_awlock(v_awlock),
        .o_ram_awcache(v_awcache), .o_ram_awprot(v_awprot), .o_ram_awregion(v_awregion),
        .o_ram_awqos(v_awqos), .o_ram_awvalid(v_awvalid), .i_ram_awready(v_awready),
        .o_ram_wdata(v_wdata), .o_ram_wstrb(v_wstrb), .o_ram_wlast(v_wlast),
        .o_ram_wvalid(v_wvalid), .i_ram_wready(v_wready),
        .i_ram_bid(v_bid), .i_ram_bresp(v_bresp), .i_ram_bvalid(v_bvalid), .o_ram_bready(v_bready),
        .o_ram_arid(v_arid), .o_ram_araddr(v_araddr), .o_ram_arlen(v_arlen),
        .o_ram_arsize(v_arsize), .o_ram_arburst(v_arburst), .o_ram_arlock(v_arlock),
        .o_ram_arcache(v_arcache), .o_ram_arprot(v_arprot), .o_ram_arregion(v_arregion),
        .o_ram_arqos(v_arqos), .o_ram_arvalid(v_arvalid), .i_ram_arready(v_arready),
        .i_ram_rid(v_rid), .i_ram_rdata(v_rdata), .i_ram_rresp(v_rresp),
        .i_ram_rlast(v_rlast), .i_ram_rvalid(v_rvalid), .o_ram_rready(v_rready),
        .o_init_done(v_done), .o_init_error(v_error), .o_err_addr(v_err_addr)
    );

    int checks = 0;
    int errors = 0;
    string tname = "init";

    logic [31:0] exp_aw[$];
    logic [63:0] exp_w[$];
    logic [31:0] exp_ar[$];
    logic [32:0] exp_fin[$];

    int          max_dly = 0;
    logic [31:0] corrupt_addr = NONE;
    int          bad_b_idx = -1;
    int          n_aw = 0;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s actual=%h required=%h", tname, n, act, exp);
        end
    endtask

    task automatic bad(input string n, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s/%s unexpected value=%h", tname, n, act);
    endtask

    // Monitor / scoreboard: samples pre-edge values at each rising edge.
    initial begin
        logic aw_st, w_st, ar_st, done_q;
        logic [31:0] aw_prev, ar_prev;
        logic [63:0] w_prev;
        aw_st = 0; w_st = 0; ar_st = 0; done_q = 0;
        aw_prev = '0; ar_prev = '0; w_prev = '0;
        forever begin
            @(posedge clk);
            if (!rstn) begin
                aw_st = 0; w_st = 0; ar_st = 0; done_q = 0;
            end else begin
                if (aw_st) chk("aw_stable", {o_ram_awvalid, o_ram_awaddr}, {1'b1, aw_prev});
                if (w_st)  chk("w_stable", {o_ram_wvalid, o_ram_wdata}, {1'b1, w_prev});
                if (ar_st) chk("ar_stable", {o_ram_arvalid, o_ram_araddr}, {1'b1, ar_prev});
                if (o_ram_awvalid && i_ram_awready) begin
                    if (exp_aw.size() == 0) bad("aw_extra", o_ram_awaddr);
                    else chk("awaddr", o_ram_awaddr, exp_aw.pop_front());
                    chk("aw_fields", {o_ram_awid, o_ram_awlen, o_ram_awsize, o_ram_awburst, o_ram_awlock,
                                      o_ram_awcache, o_ram_awprot, o_ram_awregion, o_ram_awqos},
                        {6'd0, 8'd0, 3'd3, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0});
                end
                if (o_ram_wvalid && i_ram_wready) begin
                    if (exp_w.size() == 0) bad("w_extra", o_ram_wdata);
                    else chk("wdata", o_ram_wdata, exp_w.pop_front());
                    chk("w_fields", {o_ram_wstrb, o_ram_wlast}, {8'hFF, 1'b1});
                end
                if (o_ram_arvalid && i_ram_arready) begin
                    if (exp_ar.size() == 0) bad("ar_extra", o_ram_araddr);
                    else chk("araddr", o_ram_araddr, exp_ar.pop_front());
                    chk("ar_fields", {o_ram_arid, o_ram_arlen, o_ram_arsize, o_ram_arburst, o_ram_arlock,
                                      o_ram_arcache, o_ram_arprot, o_ram_arregion, o_ram_arqos},
                        {6'd0, 8'd0, 3'd3, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0});
                end
                if (o_init_done && !done_q) begin
                    if (exp_fin.size() == 0) bad("done_extra", {o_init_error, o_err_addr});
                    else chk("final_status", {o_init_error, o_err_addr}, exp_fin.pop_front());
                end
                aw_st = o_ram_awvalid && !i_ram_awready; aw_prev = o_ram_awaddr;
                w_st  = o_ram_wvalid && !i_ram_wready;   w_prev  = o_ram_wdata;
                ar_st = o_ram_arvalid && !i_ram_arready; ar_prev = o_ram_araddr;
                done_q = o_init_done;
            end
        end
    end

    // RAM responder for the verifying instance: handshakes seen at the rising
    // edge, responses and readies driven at the falling edge.
    initial begin
        logic [63:0] mem [8];
        logic awf, wf, bf, arf, rf, aw_have, w_have, b_pend, r_pend;
        logic [31:0] cap_aw, cap_ar;
        logic [63:0] cap_w;
        int aw_dly, w_dly, ar_dly, b_dly, r_dly, wr_idx;
        logic [1:0] b_code;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        i_ram_awready = 0; i_ram_wready = 0; i_ram_arready = 0;
        i_ram_bvalid = 0; i_ram_bresp = 0; i_ram_bid = 0;
        i_ram_rvalid = 0; i_ram_rdata = 0; i_ram_rresp = 0; i_ram_rlast = 0; i_ram_rid = 0;
        aw_have = 0; w_have = 0; b_pend = 0; r_pend = 0; b_code = 0;
        aw_dly = 0; w_dly = 0; ar_dly = 0; b_dly = 0; r_dly = 0; wr_idx = 0;
        cap_aw = 0; cap_ar = 0; cap_w = 0;
        forever begin
            @(posedge clk);
            awf = o_ram_awvalid && i_ram_awready;
            wf  = o_ram_wvalid && i_ram_wready;
            bf  = i_ram_bvalid && o_ram_bready;
            arf = o_ram_arvalid && i_ram_arready;
            rf  = i_ram_rvalid && o_ram_rready;
            if (awf) cap_aw = o_ram_awaddr;
            if (wf)  cap_w  = o_ram_wdata;
            if (arf) cap_ar = o_ram_araddr;
            @(negedge clk);
            if (!rstn) begin
                i_ram_awready = 0; i_ram_wready = 0; i_ram_arready = 0;
                i_ram_bvalid = 0; i_ram_rvalid = 0;
                aw_have = 0; w_have = 0; b_pend = 0; r_pend = 0;
                aw_dly = 0; w_dly = 0; ar_dly = 0; wr_idx = 0; n_aw = 0;
                continue;
            end
            if (awf) begin aw_have = 1; n_aw++; end
            if (wf)  w_have = 1;
            if (bf)  i_ram_bvalid = 0;
            if (rf)  i_ram_rvalid = 0;
            if (aw_have && w_have) begin
                mem[cap_aw[5:3]] = cap_w;
                b_code = (wr_idx == bad_b_idx) ? 2'b10 : 2'b00;
                wr_idx++;
                b_pend = 1; b_dly = $urandom_range(max_dly);
                aw_have = 0; w_have = 0;
            end
            if (b_pend) begin
                if (b_dly == 0) begin i_ram_bvalid = 1; i_ram_bresp = b_code; b_pend = 0; end
                else b_dly--;
            end
            if (arf) begin r_pend = 1; r_dly = $urandom_range(max_dly); end
            if (r_pend) begin
                if (r_dly == 0) begin
                    i_ram_rvalid = 1; i_ram_rlast = 1; i_ram_rresp = 0; r_pend = 0;
                    i_ram_rdata = mem[cap_ar[5:3]] ^ ((cap_ar == corrupt_addr) ? 64'd1 : 64'd0);
                end else r_dly--;
            end
            i_ram_awready = 0;
            if (o_ram_awvalid && !aw_have) begin
                if (aw_dly == 0) begin i_ram_awready = 1; aw_dly = $urandom_range(max_dly); end
                else aw_dly--;
            end
            i_ram_wready = 0;
            if (o_ram_wvalid && !w_have) begin
                if (w_dly == 0) begin i_ram_wready = 1; w_dly = $urandom_range(max_dly); end
                else w_dly--;
            end
            i_ram_arready = 0;
            if (o_ram_arvalid) begin
                if (ar_dly == 0) begin i_ram_arready = 1; ar_dly = $urandom_range(max_dly); end
                else ar_dly--;
            end
        end
    end

    // Zero-wait write-only responder for the non-verifying instance.
    int v_bcnt = 0;
    int v_ar_seen = 0;
    initial begin
        logic vf, vbf;
        v_awready = 1; v_wready = 1; v_arready = 1;
        v_bvalid = 0; v_bresp = 0; v_bid = 0;
        v_rvalid = 0; v_rdata = 0; v_rresp = 0; v_rlast = 0; v_rid = 0;
        forever begin
            @(posedge clk);
            vf  = v_awvalid && v_wvalid;
            vbf = v_bvalid && v_bready;
            if (rstn && v_arvalid) v_ar_seen++;
            @(negedge clk);
            if (!rstn) begin v_bvalid = 0; v_bcnt = 0; v_ar_seen = 0; continue; end
            if (vbf) begin v_bvalid = 0; v_bcnt++; end
            if (vf) v_bvalid = 1;
        end
    end

    task automatic run_test(input string n, input int md, input logic [31:0] corr, input int badb,
                            input int n_wr, input int n_rd, input logic err, input logic [31:0] eaddr,
                            input bit mid_rst, input bit main_run);
        int cyc;
        int viol;
        bit hit;
        @(negedge clk);
        rstn = 0;
        tname = n; max_dly = md; corrupt_addr = corr; bad_b_idx = badb;
        exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_fin.delete();
        repeat (3) @(negedge clk);
        if (mid_rst) begin
            for (int i = 0; i < 6; i++) begin exp_aw.push_back(32'(i * 8)); exp_w.push_back(PAT[i]); end
            rstn = 1;
            hit = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk); #1;
                if (n_aw == 6) begin hit = 1; break; end
            end
            if (!hit) bad("mid_wait_timeout", 64'(n_aw));
            chk("bready_before_reset", o_ram_bready, 1'b1);
            rstn = 0;
            #1;
            chk("async_clear", {o_ram_awvalid, o_ram_wvalid, o_ram_bready, o_ram_arvalid, o_ram_rready,
                                o_init_done, o_init_error, o_err_addr}, '0);
            exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_fin.delete();
            repeat (3) @(negedge clk);
        end
        for (int i = 0; i < n_wr; i++) begin exp_aw.push_back(32'(i * 8)); exp_w.push_back(PAT[i]); end
        for (int i = 0; i < n_rd; i++) exp_ar.push_back(32'(i * 8));
        exp_fin.push_back({err, eaddr});
        chk("reset_state", {o_ram_awvalid, o_ram_wvalid, o_ram_bready, o_ram_arvalid, o_ram_rready,
                            o_init_done, o_init_error, o_err_addr}, '0);
        rstn = 1;
        hit = 0;
        cyc = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (o_init_done) begin hit = 1; cyc = i + 1; break; end
        end
        if (!hit) bad("done_timeout", {o_init_done, o_init_error});
        if (main_run) begin
            chk("latency_32_to_34", (cyc >= 32 && cyc <= 34), 1'b1);
            chk("noverify_status", {v_done, v_error, v_err_addr}, {1'b1, 1'b0, 32'h0});
            chk("noverify_bcount", 64'(v_bcnt), 64'd8);
            chk("noverify_no_ar", 64'(v_ar_seen), 64'd0);
        end
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_ram_awvalid || o_ram_wvalid || o_ram_bready || o_ram_arvalid || o_ram_rready || !o_init_done)
                viol++;
        end
        chk("done_quiet", 64'(viol), 64'd0);
        chk("leftover", {8'(exp_aw.size()), 8'(exp_w.size()), 8'(exp_ar.size()), 8'(exp_fin.size())}, '0);
    endtask

    initial begin
        run_test("zero_wait",    0, NONE,     -1, 8, 8, 1'b0, 32'h0,  1'b0, 1'b1);
        run_test("random_ready", 5, NONE,     -1, 8, 8, 1'b0, 32'h0,  1'b0, 1'b0);
        run_test("read_corrupt", 3, 32'h20,   -1, 8, 5, 1'b1, 32'h20, 1'b0, 1'b0);
        run_test("bresp_error",  2, NONE,      2, 3, 0, 1'b1, 32'h10, 1'b0, 1'b0);
        run_test("mid_reset",    0, NONE,     -1, 8, 8, 1'b0, 32'h0,  1'b1, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
